// File: rtl/ysyx_23060208_mem_arbiter_pkg.sv
// Shared types and constants for the two-master AXI4-Lite memory arbiter.
// Holds the arbiter state encodings, grant identifiers and AXI response codes.
package ysyx_23060208_mem_arbiter_pkg;

  localparam int ARB_DW = 32;
  localparam int ARB_SW = ARB_DW / 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_RD_M0 = 2'd1,
    ARB_RD_M1 = 2'd2,
    ARB_WR_M1 = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } grant_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_23060208_mem_arbiter_rr_arb2.sv
// Two-input round-robin grant. The master not granted last wins a tie;
// last-grant is only updated when the caller accepts the grant (i_take).
module ysyx_23060208_mem_arbiter_rr_arb2
  import ysyx_23060208_mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_take,
  output logic o_gnt0,
  output logic o_gnt1
);

  grant_e r_last;
  logic   w_gnt0;
  logic   w_gnt1;

  assign w_gnt1 = i_req1 & (~i_req0 | (r_last == GNT_M0));
  assign w_gnt0 = i_req0 & ~w_gnt1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last <= GNT_M0;
    end else if (i_take && (w_gnt0 || w_gnt1)) begin
      r_last <= w_gnt1 ? GNT_M1 : GNT_M0;
    end
  end

  assign o_gnt0 = w_gnt0;
  assign o_gnt1 = w_gnt1;

endmodule

// File: rtl/ysyx_23060208_mem_arbiter.sv
// Shares one AXI4-Lite SRAM port between the IFU (M0, read-only) and the EXU (M1).
// One whole transaction is granted at a time; responses go to the granted master only.
module ysyx_23060208_mem_arbiter
  import ysyx_23060208_mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = ARB_DW,
  parameter int STRB_WIDTH = ARB_SW
) (
  input  logic                  clk,
  input  logic                  rst,
  // M0: IFU read
  input  logic [DATA_WIDTH-1:0] m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  // M1: EXU load/store
  input  logic [DATA_WIDTH-1:0] m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  input  logic [DATA_WIDTH-1:0] m1_awaddr,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [STRB_WIDTH-1:0] m1_wstrb,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic [1:0]            m1_bresp,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,
  // Slave (SRAM) port
  output logic [DATA_WIDTH-1:0] s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [DATA_WIDTH-1:0] s_awaddr,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic [STRB_WIDTH-1:0] s_wstrb,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [1:0]            s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready,
  // Debug
  output arb_state_e            o_dbg_state
);

  // Handshake rule: a transfer happens on a posedge where valid and ready are both 1;
  // a source holds valid (and its payload) until that edge and never waits on ready.

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_rd_m0;
  logic       w_rd_m1;
  logic       w_wr_m1;
  logic       r_ar_done;
  logic       r_aw_done;
  logic       r_w_done;

  ysyx_23060208_mem_arbiter_rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .i_req0 (m0_arvalid),
    .i_req1 (m1_arvalid | m1_awvalid),
    .i_take (r_state == ARB_IDLE),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        // Within M1 a pending store outranks a pending load.
        if (w_gnt1)      w_state_nxt = m1_awvalid ? ARB_WR_M1 : ARB_RD_M1;
        else if (w_gnt0) w_state_nxt = ARB_RD_M0;
      end
      ARB_RD_M0, ARB_RD_M1: if (s_rvalid && s_rready) w_state_nxt = ARB_IDLE;
      ARB_WR_M1:            if (s_bvalid && s_bready) w_state_nxt = ARB_IDLE;
      default:              w_state_nxt = ARB_IDLE;
    endcase
  end

  // Address/data requests are forwarded once per grant, so a master that
  // re-asserts early cannot slip a second transfer into the same grant.
  always_ff @(posedge clk) begin
    if (!rst || r_state == ARB_IDLE) begin
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (s_arvalid && s_arready) r_ar_done <= 1'b1;
      if (s_awvalid && s_awready) r_aw_done <= 1'b1;
      if (s_wvalid && s_wready)   r_w_done  <= 1'b1;
    end
  end

  assign w_rd_m0 = (r_state == ARB_RD_M0);
  assign w_rd_m1 = (r_state == ARB_RD_M1);
  assign w_wr_m1 = (r_state == ARB_WR_M1);

  always_comb begin
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = '0;
    m1_bvalid  = 1'b0;
    if (w_rd_m0) begin
      s_araddr   = m0_araddr;
      s_arvalid  = m0_arvalid & ~r_ar_done;
      m0_arready = s_arready & ~r_ar_done;
      m0_rdata   = s_rdata;
      m0_rresp   = s_rresp;
      m0_rvalid  = s_rvalid;
      s_rready   = m0_rready;
    end
    if (w_rd_m1) begin
      s_araddr   = m1_araddr;
      s_arvalid  = m1_arvalid & ~r_ar_done;
      m1_arready = s_arready & ~r_ar_done;
      m1_rdata   = s_rdata;
      m1_rresp   = s_rresp;
      m1_rvalid  = s_rvalid;
      s_rready   = m1_rready;
    end
    if (w_wr_m1) begin
      s_awaddr   = m1_awaddr;
      s_awvalid  = m1_awvalid & ~r_aw_done;
      m1_awready = s_awready & ~r_aw_done;
      s_wdata    = m1_wdata;
      s_wstrb    = m1_wstrb;
      s_wvalid   = m1_wvalid & ~r_w_done;
      m1_wready  = s_wready & ~r_w_done;
      m1_bresp   = s_bresp;
      m1_bvalid  = s_bvalid;
      s_bready   = m1_bready;
    end
  end

  assign o_dbg_state = r_state;

endmodule
